// File: rtl/alu_control_unit.sv
// MIPS ALU-control decoder: (ALUop, func) -> 4-bit ALU operation select plus illegal-func flag.
// Latency: one clk; outputs are registered, synchronous active-high clear.
// Backpressure: none; a new decode is captured on every rising edge.
module alu_control_unit #(
    parameter logic [3:0] ILLEGAL_CODE = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ALUop,
    input  logic [5:0] func,
    output logic [3:0] ALUControl,
    output logic       illegal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    logic [3:0] alu_control_d;
    logic [3:0] alu_control_q;
    logic       illegal_d;
    logic       illegal_q;

    always_comb begin
        alu_control_d = ALU_AND;
        illegal_d     = 1'b0;
        case (ALUop)
            3'b000: begin
                // Variable shifts share the ALU op of their immediate forms; JR only needs a pass-through add.
                case (func)
                    6'b000000, 6'b000100: alu_control_d = ALU_SLL;
                    6'b000010, 6'b000110: alu_control_d = ALU_SRL;
                    6'b000011, 6'b000111: alu_control_d = ALU_SRA;
                    6'b100000, 6'b100001: alu_control_d = ALU_ADD;
                    6'b001000:            alu_control_d = ALU_ADD;
                    6'b100010, 6'b100011: alu_control_d = ALU_SUB;
                    6'b100100:            alu_control_d = ALU_AND;
                    6'b100101:            alu_control_d = ALU_OR;
                    6'b100110:            alu_control_d = ALU_XOR;
                    6'b100111:            alu_control_d = ALU_NOR;
                    6'b101010:            alu_control_d = ALU_SLT;
                    6'b101011:            alu_control_d = ALU_SLTU;
                    default: begin
                        alu_control_d = ILLEGAL_CODE;
                        illegal_d     = 1'b1;
                    end
                endcase
            end
            3'b001:  alu_control_d = ALU_ADD;
            3'b010:  alu_control_d = ALU_SUB;
            3'b011:  alu_control_d = ALU_AND;
            3'b100:  alu_control_d = ALU_OR;
            3'b101:  alu_control_d = ALU_XOR;
            3'b110:  alu_control_d = ALU_SLT;
            default: alu_control_d = ALU_LUI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_control_q <= 4'b0000;
            illegal_q     <= 1'b0;
        end else begin
            alu_control_q <= alu_control_d;
            illegal_q     <= illegal_d;
        end
    end

    assign ALUControl = alu_control_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench for alu_control_unit: driver queues hand-computed results, monitor checks them one edge later.
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ALUop = 3'b000;
    logic [5:0] func = 6'b000000;
    logic [3:0] ALUControl;
    logic       illegal;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] exp_ctrl_q[$];
    logic       exp_ill_q[$];
    string      exp_name_q[$];

    alu_control_unit #(.ILLEGAL_CODE(4'b1111)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUop      (ALUop),
        .func       (func),
        .ALUControl (ALUControl),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the matching result is expected after the next rising edge.
    task automatic drive(input logic r, input logic [2:0] op, input logic [5:0] f,
                         input logic [3:0] ec, input logic ei, input string nm);
        @(negedge clk);
        rst   = r;
        ALUop = op;
        func  = f;
        exp_ctrl_q.push_back(ec);
        exp_ill_q.push_back(ei);
        exp_name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [3:0] ec;
        logic       ei;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_ctrl_q.size() > 0) begin
                ec = exp_ctrl_q.pop_front();
                ei = exp_ill_q.pop_front();
                nm = exp_name_q.pop_front();
                tests_run++;
                if (ALUControl !== ec || illegal !== ei) begin
                    tests_failed++;
                    $display("FAIL %s: got ALUControl=%b illegal=%b, expected ALUControl=%b illegal=%b",
                             nm, ALUControl, illegal, ec, ei);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset has priority over a valid ADD decode, then decode resumes.
        drive(1'b1, 3'b001, 6'b100010, 4'b0000, 1'b0, "reset_clears");
        drive(1'b0, 3'b001, 6'b100010, 4'b0010, 1'b0, "reset_release_add");

        // R-type sweep
        drive(1'b0, 3'b000, 6'b000000, 4'b0100, 1'b0, "r_sll");
        drive(1'b0, 3'b000, 6'b000010, 4'b0101, 1'b0, "r_srl");
        drive(1'b0, 3'b000, 6'b100000, 4'b0010, 1'b0, "r_add");
        drive(1'b0, 3'b000, 6'b100010, 4'b0110, 1'b0, "r_sub");
        drive(1'b0, 3'b000, 6'b100111, 4'b1100, 1'b0, "r_nor");
        drive(1'b0, 3'b000, 6'b101010, 4'b0111, 1'b0, "r_slt");
        drive(1'b0, 3'b000, 6'b101011, 4'b1001, 1'b0, "r_sltu");

        // Illegal R-type funcs and recovery
        drive(1'b0, 3'b000, 6'b000001, 4'b1111, 1'b1, "r_illegal_01");
        drive(1'b0, 3'b000, 6'b111111, 4'b1111, 1'b1, "r_illegal_3f");
        drive(1'b0, 3'b000, 6'b100100, 4'b0000, 1'b0, "r_and_recover");

        // Non-R classes
        drive(1'b0, 3'b001, 6'b000000, 4'b0010, 1'b0, "op_add");
        drive(1'b0, 3'b010, 6'b000000, 4'b0110, 1'b0, "op_sub");
        drive(1'b0, 3'b011, 6'b000000, 4'b0000, 1'b0, "op_and");
        drive(1'b0, 3'b100, 6'b000000, 4'b0001, 1'b0, "op_or");
        drive(1'b0, 3'b101, 6'b000000, 4'b0011, 1'b0, "op_xor");
        drive(1'b0, 3'b110, 6'b000000, 4'b0111, 1'b0, "op_slt");
        drive(1'b0, 3'b111, 6'b000000, 4'b1010, 1'b0, "op_lui");

        // func ignored outside R-type, even an illegal R-type func
        drive(1'b0, 3'b010, 6'b000001, 4'b0110, 1'b0, "op_sub_func_ignored");
        drive(1'b0, 3'b111, 6'b111111, 4'b1010, 1'b0, "op_lui_func_ignored");

        // Back-to-back changes every cycle, covering aliases and JR
        drive(1'b0, 3'b000, 6'b000100, 4'b0100, 1'b0, "lat_sllv");
        drive(1'b0, 3'b000, 6'b000111, 4'b1000, 1'b0, "lat_srav");
        drive(1'b0, 3'b000, 6'b100001, 4'b0010, 1'b0, "lat_addu");
        drive(1'b0, 3'b000, 6'b100011, 4'b0110, 1'b0, "lat_subu");
        drive(1'b0, 3'b000, 6'b001000, 4'b0010, 1'b0, "lat_jr");
        drive(1'b0, 3'b000, 6'b100101, 4'b0001, 1'b0, "lat_or");
        drive(1'b0, 3'b000, 6'b000011, 4'b1000, 1'b0, "lat_sra");
        drive(1'b0, 3'b000, 6'b000110, 4'b0101, 1'b0, "lat_srlv");
        drive(1'b0, 3'b000, 6'b100110, 4'b0011, 1'b0, "lat_xor");

        // Mid-stream reset over an illegal func, then resume
        drive(1'b1, 3'b000, 6'b111110, 4'b0000, 1'b0, "mid_reset_over_illegal");
        drive(1'b0, 3'b000, 6'b111110, 4'b1111, 1'b0 | 1'b1, "mid_reset_resume_illegal");
        drive(1'b0, 3'b110, 6'b101010, 4'b0111, 1'b0, "mid_reset_resume_slt");

        // Drain the scoreboard
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (exp_ctrl_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_ctrl_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
